refresh_timer: RTL and testbench

//  Initiator side of the DRAM refresh request interface. Divides CLK into

---
 rtl/ram_pkg.sv | 19 +
 rtl/slot_divider.sv | 36 +++
 rtl/refresh_timer.sv | 146 ++++++++++++++
 tb/tb_refresh_timer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM controller slice: refresh FSM state
// encoding, the default refresh divider for a 25MHz clock, and the width
// of the owed-refresh counter.
package ram_pkg;

    // Refresh request FSM states
    typedef enum logic [1:0] {
        RT_IDLE = 2'd0,
        RT_REQ  = 2'd1,
        RT_GAP  = 2'd2
    } rtState_t;

    // 15.6us refresh slot at 25MHz
    localparam int REF_DIV_25MHZ = 390;

    // Owed-refresh count is 3 bits wide (saturates at 7)
    localparam int PEND_W = 3;

endpackage : ram_pkg

// File: rtl/slot_divider.sv
// Refresh slot divider: a reloading down-counter that emits a one-clock
// registered tick every DIV enabled clocks. EN=0 freezes the count.
module slot_divider
    import ram_pkg::*;
#(
    parameter int DIV = REF_DIV_25MHZ
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic tick
);

    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

    logic [TW-1:0] timerReg;

    // Count down while enabled; the reload clock also registers the tick pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            timerReg <= RELOAD;
            tick     <= 1'b0;
        end else begin
            tick <= EN && (timerReg == '0);
            if (EN) begin
                if (timerReg == '0) begin
                    timerReg <= RELOAD;
                end else begin
                    timerReg <= timerReg - TW'(1);
                end
            end
        end
    end

endmodule : slot_divider

// File: rtl/refresh_timer.sv
// Refresh request initiator: counts owed refreshes from the slot divider
// and drives the level-type RefReq/RefUrg handshake to the RAM controller,
// retiring one owed refresh per RefAck taken while requesting.
module refresh_timer
    import ram_pkg::*;
#(
    parameter int DIV       = REF_DIV_25MHZ,
    parameter int URG_AFTER = 128,
    parameter int URG_PEND  = 2,
    parameter int MAX_PEND  = 7,
    parameter int GAP_CYC   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrg,
    output logic [PEND_W-1:0] Pending,
    output logic              Overrun
);

    localparam int AW = $clog2(URG_AFTER + 1);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [AW-1:0]     AGE_SAT  = AW'(URG_AFTER);
    localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URG_PEND);

    logic              tick;
    rtState_t          stateReg;
    logic [AW-1:0]     ageReg;
    logic [AW-1:0]     ageNext;
    logic [GW-1:0]     gapReg;
    logic [PEND_W-1:0] pendingReg;
    logic [PEND_W-1:0] pendingNext;
    logic              overrunReg;
    logic              overrunNext;
    logic              ackTaken;
    logic              pendHigh;

    slot_divider #(
        .DIV (DIV)
    ) u_slot_divider (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .tick (tick)
    );

    // Next owed-refresh count and request age; acks only count while requesting
    always_comb begin
        ackTaken    = RefAck && (stateReg == RT_REQ);
        pendingNext = pendingReg;
        overrunNext = overrunReg;
        if (tick && !ackTaken) begin
            if (pendingReg == PEND_MAX) begin
                overrunNext = 1'b1;
            end else begin
                pendingNext = pendingReg + PEND_W'(1);
            end
        end else if (ackTaken && !tick && (pendingReg != '0)) begin
            pendingNext = pendingReg - PEND_W'(1);
        end
        pendHigh = (pendingNext >= PEND_URG);
        ageNext  = (ageReg >= AGE_SAT) ? AGE_SAT : (ageReg + AW'(1));
    end

    // Debt counter and sticky overrun flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            pendingReg <= '0;
            overrunReg <= 1'b0;
        end else begin
            pendingReg <= pendingNext;
            overrunReg <= overrunNext;
        end
    end

    // Request FSM with registered RefReq/RefUrg; GAP forces a low period after every ack
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg <= RT_IDLE;
            ageReg   <= '0;
            gapReg   <= '0;
            RefReq   <= 1'b0;
            RefUrg   <= 1'b0;
        end else begin
            case (stateReg)
                RT_IDLE: begin
                    ageReg <= '0;
                    if (pendingNext != '0) begin
                        stateReg <= RT_REQ;
                        RefReq   <= 1'b1;
                        RefUrg   <= pendHigh;
                    end else begin
                        RefReq <= 1'b0;
                        RefUrg <= 1'b0;
                    end
                end
                RT_REQ: begin
                    if (ackTaken) begin
                        stateReg <= RT_GAP;
                        gapReg   <= GAP_LOAD;
                        ageReg   <= '0;
                        RefReq   <= 1'b0;
                        RefUrg   <= 1'b0;
                    end else begin
                        ageReg <= ageNext;
                        RefReq <= 1'b1;
                        RefUrg <= (ageNext >= AGE_SAT) || pendHigh;
                    end
                end
                RT_GAP: begin
                    ageReg <= '0;
                    if (gapReg == '0) begin
                        if (pendingNext != '0) begin
                            stateReg <= RT_REQ;
                            RefReq   <= 1'b1;
                            RefUrg   <= pendHigh;
                        end else begin
                            stateReg <= RT_IDLE;
                            RefReq   <= 1'b0;
                            RefUrg   <= 1'b0;
                        end
                    end else begin
                        gapReg <= gapReg - GW'(1);
                        RefReq <= 1'b0;
                        RefUrg <= 1'b0;
                    end
                end
                default: begin
                    stateReg <= RT_IDLE;
                    ageReg   <= '0;
                    RefReq   <= 1'b0;
                    RefUrg   <= 1'b0;
                end
            endcase
        end
    end

    assign Pending = pendingReg;
    assign Overrun = overrunReg;

endmodule : refresh_timer

// File: tb/tb_refresh_timer.sv
// Bench for refresh_timer: directed scenarios followed by random EN/RefAck/RST
// traffic, every clock compared against a behavioural model of the refresh
// rules (slot counting by enabled clocks, debt arithmetic, forced-low window).
module tb_refresh_timer;

    localparam int DIV_T = 16;
    localparam int UA    = 128;
    localparam int UP    = 2;
    localparam int MP    = 7;
    localparam int GC    = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       RefAck = 1'b0;
    logic       RefReq;
    logic       RefUrg;
    logic [2:0] Pending;
    logic       Overrun;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;
    int lowCnt;

    // Reference model state
    int mEnCnt = 0;
    bit mTick  = 0;
    int mPend  = 0;
    bit mOver  = 0;
    bit mReq   = 0;
    bit mUrg   = 0;
    int mAge   = 0;
    int mLow   = 0;

    refresh_timer #(
        .DIV       (DIV_T),
        .URG_AFTER (UA),
        .URG_PEND  (UP),
        .MAX_PEND  (MP),
        .GAP_CYC   (GC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .RefAck  (RefAck),
        .RefReq  (RefReq),
        .RefUrg  (RefUrg),
        .Pending (Pending),
        .Overrun (Overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Drive one clock of inputs, advance the model across the edge, compare
    task automatic step(input logic r, input logic e, input logic a);
        bit tickNow;
        bit served;
        RST    = r;
        EN     = e;
        RefAck = a;
        @(posedge CLK);
        cyc++;
        if (r) begin
            mEnCnt = 0; mTick = 0; mPend = 0; mOver = 0;
            mReq = 0; mUrg = 0; mAge = 0; mLow = 0;
        end else begin
            tickNow = mTick;
            served  = a && mReq;
            if (e) mEnCnt++;
            mTick = e && ((mEnCnt % DIV_T) == 0);
            if (tickNow && !served) begin
                if (mPend == MP) mOver = 1;
                else mPend++;
            end else if (served && !tickNow && mPend > 0) begin
                mPend--;
            end
            if (served) begin
                mReq = 0; mLow = GC; mAge = 0;
            end else if (mReq) begin
                mAge = (mAge + 1 > UA) ? UA : mAge + 1;
            end else begin
                if (mLow > 0) mLow--;
                if (mLow == 0 && mPend > 0) begin
                    mReq = 1; mAge = 0;
                end
            end
            mUrg = mReq && (mAge >= UA || mPend >= UP);
            if (served) $display("cycle %0d: refresh ack taken, pending now %0d", cyc, mPend);
        end
        #1;
        check("model_req", RefReq, mReq);
        check("model_urg", RefUrg, mUrg);
        check("model_pend", Pending, mPend);
        check("model_over", Overrun, mOver);
        check("urg_needs_req", RefUrg && !RefReq, 0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_req", RefReq, 0);
        check("rst_urg", RefUrg, 0);
        check("rst_pend", Pending, 0);
        check("rst_over", Overrun, 0);

        // First tick at clk 16, RefReq at 17, second tick makes it urgent at 33
        repeat (16) step(0, 1, 0);
        check("t1_req16", RefReq, 0);
        check("t1_pend16", Pending, 0);
        step(0, 1, 0);
        check("t1_req17", RefReq, 1);
        check("t1_pend17", Pending, 1);
        check("t1_urg17", RefUrg, 0);
        repeat (15) step(0, 1, 0);
        check("t1_urg32", RefUrg, 0);
        step(0, 1, 0);
        check("t1_pend33", Pending, 2);
        check("t1_urg33", RefUrg, 1);

        // Age-driven urgency: freeze the timer after the first request
        step(1, 0, 0);
        repeat (17) step(0, 1, 0);
        repeat (127) step(0, 0, 0);
        check("age_urg144", RefUrg, 0);
        step(0, 0, 0);
        check("age_urg145", RefUrg, 1);

        // Single ack retires the debt, request stays low afterwards
        step(0, 0, 1);
        check("t2_req", RefReq, 0);
        check("t2_pend", Pending, 0);
        repeat (10) begin
            step(0, 0, 0);
            check("t2_idle_req", RefReq, 0);
        end

        // Three owed refreshes served back to back with the mandatory gap
        step(1, 0, 0);
        repeat (49) step(0, 1, 0);
        check("t3_pend", Pending, 3);
        for (int r = 0; r < 3; r++) begin
            check("t3_req_hi", RefReq, 1);
            step(0, 0, 1);
            lowCnt = 0;
            for (int k = 0; k < 20; k++) begin
                if (RefReq) break;
                lowCnt++;
                step(0, 0, 0);
            end
            check("t3_low_len", lowCnt, (r < 2) ? GC : 20);
        end
        check("t3_pend_end", Pending, 0);

        // Tick and ack in the same clock
        step(1, 0, 0);
        repeat (48) step(0, 1, 0);
        check("t4_pend_pre", Pending, 2);
        check("t4_req_pre", RefReq, 1);
        step(0, 1, 1);
        check("t4_pend", Pending, 2);
        check("t4_req_gap", RefReq, 0);
        step(0, 0, 0);
        check("t4_req_gap2", RefReq, 0);
        step(0, 0, 0);
        check("t4_req_back", RefReq, 1);

        // Saturation and sticky overrun
        step(1, 0, 0);
        repeat (140) step(0, 1, 0);
        check("t5_pend_sat", Pending, 7);
        check("t5_over", Overrun, 1);
        step(0, 1, 1);
        check("t5_pend_ack", Pending, 6);
        check("t5_over_ack", Overrun, 1);
        repeat (5) step(0, 1, 0);
        check("t5_over_sticky", Overrun, 1);

        // Reset during an urgent request
        step(1, 0, 0);
        repeat (66) step(0, 1, 0);
        check("t6_pend_pre", Pending, 4);
        check("t6_req_pre", RefReq, 1);
        check("t6_urg_pre", RefUrg, 1);
        step(1, 1, 0);
        check("t6_req_rst", RefReq, 0);
        check("t6_urg_rst", RefUrg, 0);
        check("t6_pend_rst", Pending, 0);
        check("t6_over_rst", Overrun, 0);
        repeat (16) step(0, 1, 0);
        check("t6_req16", RefReq, 0);
        step(0, 1, 0);
        check("t6_req17", RefReq, 1);
        check("t6_pend17", Pending, 1);

        // Random traffic against the model
        repeat (1500) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule : tb_refresh_timer
